swap_key_sequencer: RTL
=======================

# swap_key_sequencer

Sequencing controller for the bit-swap/invert datapath used in the cartridge and data-stream descrambling path. It holds a per-stream swap key and invert key and drives the swapper's `swap`/`invert` controls for every accepted word. It advances the key schedule after each word and streams descrambled words out over a valid/ready pair. It sits between the bus-side word source and the downstream consumer, with the combinational swapper as its external datapath.

## Interface

Parameters:
- `WIDTH`, 16: data word width; must be even and ≥ 4.
- `SWAP_WIDTH`, `WIDTH/2`: number of swap-pair controls.
- `INV_STEP`, 16'h0001: added to the invert key after each word, modulo 2^WIDTH.
- `LEN_WIDTH`, 16: width of the block length counter.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `keyLoad` in 1: strobe; loads keys and length, then starts a block.
- `keySwap` in `SWAP_WIDTH`: initial swap key.
- `keyInvert` in `WIDTH`: initial invert key.
- `blockLength` in `LEN_WIDTH`: number of words in the block. 0 means 2^LEN_WIDTH.
- `inValid` in 1, `inReady` out 1, `inData` in `WIDTH`: source handshake.
- `outValid` out 1, `outReady` in 1, `outData` out `WIDTH`: sink handshake.
- `dpSwap` out `SWAP_WIDTH`, `dpInvert` out `WIDTH`, `dpIn` out `WIDTH`: swapper controls and data.
- `dpOut` in `WIDTH`: swapper result, combinational from the `dp*` outputs.
- `busy` out 1: a block is in progress.
- `done` out 1: one-cycle pulse when the last word of a block leaves `outData`.
- `wordCount` out `LEN_WIDTH`: words accepted in the current block.

## Operation

- States: `IDLE`, `RUN`, `DRAIN`.
- `IDLE`:
  - `inReady`=0, `busy`=0.
  - `keyLoad` latches `swapKey`←`keySwap`, `invKey`←`keyInvert`, `remaining`←`blockLength`, `wordCount`←0, then goes to `RUN`.
- `RUN`:
  - `busy`=1; `inReady` = `!outValid || outReady` (one-entry output register).
  - A word is accepted when `inValid && inReady`.
  - On accept:
    - `outData`←`dpOut`, `outValid`←1, `wordCount`+1, `remaining`−1.
    - `swapKey` ← rotate-left(`swapKey`, 1).
    - `invKey` ← `invKey` + `INV_STEP`, truncated to `WIDTH`.
  - When the accepted word is the last one (`remaining`==1, or 0 meaning the wrapped maximum after 2^LEN_WIDTH words), go to `DRAIN`.
- `DRAIN`:
  - `inReady`=0.
  - When `outValid && outReady`, pulse `done`, clear `outValid` and go to `IDLE`.
- Datapath drive, continuous: `dpSwap`=`swapKey`, `dpInvert`=`invKey`, `dpIn`=`inData`.
- Per-bit swapper semantics (defines `dpOut`): pair i exchanges bits 2i and 2i+1 when `dpSwap[i]`=1, then output bit j is XORed with `dpInvert[j]`.
- `outValid` clears on `outReady` when no new word is accepted that cycle.
- Simultaneous output pop and input accept in `RUN`: `outValid` stays 1 and `outData` takes the new word.
- `keyLoad` in `RUN` or `DRAIN` aborts the block:
  - `outValid`←0 and any pending word is dropped; no `done` pulse.
  - Keys, length and counter reload; state goes to `RUN`.
  - No input word is accepted in the abort cycle.
- `keyLoad` with `blockLength`=0 runs a 2^LEN_WIDTH-word block.
- `reset` values: state `IDLE`, `outValid`=0, `outData`=0, `done`=0, `busy`=0, `wordCount`=0, `swapKey`=0, `invKey`=0, `remaining`=0. Reset wins over `keyLoad` in the same cycle.

## Timing

- Latency: a word accepted at edge N appears on `outData` with `outValid`=1 after edge N.
- Throughput: one word per clock while `outReady`=1.
- The key used for a word is the key held during its accept cycle. The updated key applies from the next cycle.
- `inReady` depends combinationally on `outReady` and state only, never on `inValid`.
- `done` is registered: it is high in the cycle after the final pop edge.
- `busy` drops in the same cycle as `done`.
- The `dp*` path is purely combinational. A registered swapper stage is not supported.

## Structure

- Shared package holds:
  - The state encoding: `IDLE`=2'd0, `RUN`=2'd1, `DRAIN`=2'd2.
  - The key-advance function: rotate plus add.
- Sub-module `key_schedule`: the `swapKey`/`invKey` registers, load, advance and reset. This lets the bench check the schedule alone.
- The FSM, counters and output register stay in the top module.
- The swapper is instantiated by the parent, not inside this block. Benches use a behavioural swapper model.

## Test plan

- Basic path, WIDTH=16, `keySwap`=8'h01, `keyInvert`=0, `INV_STEP`=1, `blockLength`=2:
  - Input 16'h0001 → `outData` 16'h0002.
  - Input 16'h0004 → `outData` 16'h0009.
  - Then `done` pulses once and `wordCount`=2.
- Backpressure: hold `outReady`=0 after the first word → `inReady`=0 and `outData` stable. Release it → the next word is accepted the same cycle with no loss or duplication.
- Length wrap: LEN_WIDTH=4, `blockLength`=0 → exactly 16 words accepted, then `done`. `swapKey` returns to its initial value every 8 words.
- Abort: `keyLoad` after the 3rd word of a 5-word block → `outValid` drops with no `done`; `wordCount`=0; the next word uses the new keys.
- Reset mid-block: assert `reset` with `outValid`=1 → the next cycle shows all outputs at reset values and `inReady`=0.
- Full-rate stream: 64 random words, `outReady` always 1 → output equals the model (swap-rotate/invert-add schedule), one word per clock.

Source files
------------

// File: rtl/swap_key_sequencer_pkg.sv
// Shared definitions for the swap/invert key sequencer: FSM encoding and the
// key-advance helpers (rotate for the swap key, modular add for the invert key).
package swap_key_sequencer_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   // Helpers work on a 64-bit carrier; callers size-cast back to their own width.
   localparam int unsigned KEY_MAX_W = 64;

   function automatic logic [KEY_MAX_W-1:0] width_mask(input int unsigned w);
      logic [KEY_MAX_W-1:0] m;
      if (w >= KEY_MAX_W) begin
         m = '1;
      end else begin
         m = (64'd1 << w) - 64'd1;
      end
      return m;
   endfunction

   function automatic logic [KEY_MAX_W-1:0] key_rotl(input logic [KEY_MAX_W-1:0] v,
                                                     input int unsigned w);
      logic [KEY_MAX_W-1:0] vm;
      vm = v & width_mask(w);
      return ((vm << 1) | (vm >> (w - 1))) & width_mask(w);
   endfunction

   function automatic logic [KEY_MAX_W-1:0] key_add(input logic [KEY_MAX_W-1:0] v,
                                                    input logic [KEY_MAX_W-1:0] step,
                                                    input int unsigned w);
      return (v + step) & width_mask(w);
   endfunction

endpackage

// File: rtl/swap_key_sequencer_key_schedule.sv
// Swap/invert key registers: load a fresh key pair, or advance both keys once
// per accepted word (swap key rotates left, invert key steps by INV_STEP).
module swap_key_sequencer_key_schedule
   import swap_key_sequencer_pkg::*;
#(
   parameter int unsigned      WIDTH      = 16,
   parameter int unsigned      SWAP_WIDTH = WIDTH / 2,
   parameter logic [WIDTH-1:0] INV_STEP   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic                  advance_i,
   input  logic [SWAP_WIDTH-1:0] swapLoad_i,
   input  logic [WIDTH-1:0]      invLoad_i,
   output logic [SWAP_WIDTH-1:0] swapKey_o,
   output logic [WIDTH-1:0]      invKey_o
);

   logic [SWAP_WIDTH-1:0] swapKey_q, swapKey_d;
   logic [WIDTH-1:0]      invKey_q,  invKey_d;

   // A load in the same cycle as an advance wins: the new block starts on fresh keys.
   always_comb begin
      swapKey_d = swapKey_q;
      invKey_d  = invKey_q;
      if (load_i) begin
         swapKey_d = swapLoad_i;
         invKey_d  = invLoad_i;
      end else if (advance_i) begin
         swapKey_d = SWAP_WIDTH'(key_rotl(64'(swapKey_q), SWAP_WIDTH));
         invKey_d  = WIDTH'(key_add(64'(invKey_q), 64'(INV_STEP), WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         swapKey_q <= '0;
         invKey_q  <= '0;
      end else begin
         swapKey_q <= swapKey_d;
         invKey_q  <= invKey_d;
      end
   end

   assign swapKey_o = swapKey_q;
   assign invKey_o  = invKey_q;

endmodule

// File: rtl/swap_key_sequencer.sv
// Sequencing controller for the external bit-swap/invert datapath: drives the
// swapper from the current keys and streams results through a one-entry output register.
module swap_key_sequencer
   import swap_key_sequencer_pkg::*;
#(
   parameter int unsigned      WIDTH      = 16,
   parameter int unsigned      SWAP_WIDTH = WIDTH / 2,
   parameter logic [WIDTH-1:0] INV_STEP   = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int unsigned      LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  keyLoad,
   input  logic [SWAP_WIDTH-1:0] keySwap,
   input  logic [WIDTH-1:0]      keyInvert,
   input  logic [LEN_WIDTH-1:0]  blockLength,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [WIDTH-1:0]      inData,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [WIDTH-1:0]      outData,
   output logic [SWAP_WIDTH-1:0] dpSwap,
   output logic [WIDTH-1:0]      dpInvert,
   output logic [WIDTH-1:0]      dpIn,
   input  logic [WIDTH-1:0]      dpOut,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  wordCount
);

   logic [1:0]            state_q,     state_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0]  wordCount_q, wordCount_d;
   logic                  outValid_q,  outValid_d;
   logic [WIDTH-1:0]      outData_q,   outData_d;
   logic                  done_q,      done_d;

   logic                  accept;
   logic                  lastWord;
   logic [SWAP_WIDTH-1:0] swapKey;
   logic [WIDTH-1:0]      invKey;

   swap_key_sequencer_key_schedule #(
      .WIDTH      (WIDTH),
      .SWAP_WIDTH (SWAP_WIDTH),
      .INV_STEP   (INV_STEP)
   ) u_key_schedule (
      .clk        (clk),
      .reset      (reset),
      .load_i     (keyLoad),
      .advance_i  (accept),
      .swapLoad_i (keySwap),
      .invLoad_i  (keyInvert),
      .swapKey_o  (swapKey),
      .invKey_o   (invKey)
   );

   // The output register can take a new word whenever it is empty or being popped.
   assign inReady  = (state_q == RUN) && (!outValid_q || outReady);
   // A reload cycle never consumes a word, even if the source handshake fires.
   assign accept   = inValid && inReady && !keyLoad;
   // A length of 0 counts down through the wrapped maximum and still ends at 1.
   assign lastWord = (remaining_q == LEN_WIDTH'(1));

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      wordCount_d = wordCount_q;
      outValid_d  = outValid_q;
      outData_d   = outData_q;
      done_d      = 1'b0;
      if (keyLoad) begin
         state_d     = RUN;
         remaining_d = blockLength;
         wordCount_d = '0;
         outValid_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            RUN: begin
               if (accept) begin
                  outData_d   = dpOut;
                  outValid_d  = 1'b1;
                  wordCount_d = wordCount_q + LEN_WIDTH'(1);
                  remaining_d = remaining_q - LEN_WIDTH'(1);
                  if (lastWord) begin
                     state_d = DRAIN;
                  end
               end else if (outReady) begin
                  outValid_d = 1'b0;
               end
            end
            DRAIN: begin
               if (outValid_q && outReady) begin
                  done_d     = 1'b1;
                  outValid_d = 1'b0;
                  state_d    = IDLE;
               end
            end
            default: begin
               state_d    = IDLE;
               outValid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         wordCount_q <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wordCount_q <= wordCount_d;
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         done_q      <= done_d;
      end
   end

   assign outValid  = outValid_q;
   assign outData   = outData_q;
   assign done      = done_q;
   assign wordCount = wordCount_q;
   assign busy      = (state_q != IDLE);
   assign dpSwap    = swapKey;
   assign dpInvert  = invKey;
   assign dpIn      = inData;

endmodule
